fusion_accumulator: RTL
=======================

// Module: fusion_accumulator
// PURPOSE
// - Downstream stage of the four quarter units that form one 8x8 fusion unit.
// - Each accepted beat, shift-combines the four 16-bit signed quarter outputs into one term per precision mode.
// - Accumulates LEN terms (one dot product) and presents the sum on a valid/ready output port.
// - Feeds the partial-sum writeback logic.
// PARAMETERS
// - ACC_W  32  accumulator/result width, signed; legal range 26..48 (elaboration error outside)
// - CNT_W  8   beat-count width; max dot-product length is 2**CNT_W-1
// PORTS
// - clk        in   1      clock; all logic on rising edge
// - rst        in   1      reset: synchronous, active-high
// - start      in   1      begin new dot product; honoured only in IDLE
// - len        in   CNT_W  beats in this dot product; sampled with start
// - mode       in   2      00=8b fused, 01=4b, 10=2b, 11=reserved; sampled with start
// - flush      in   1      abort current operation, return to IDLE
// - in_valid   in   1      quarter outputs valid this cycle
// - in_ready   out  1      stage accepts a beat
// - q0..q3     in   16 ea  signed quarter-unit outputs (q0=lo*lo, q1=hi*lo, q2=lo*hi, q3=hi*hi)
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer accepts result
// - out_data   out  ACC_W  signed accumulated result
// - busy       out  1      high in any state other than IDLE
// BEHAVIOUR
// - Reset values: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, busy=0.
// - term is signed, sign-extended to ACC_W:
//   - mode 00: term = q0 + (q1<<4) + (q2<<4) + (q3<<8)
//   - modes 01/10: term = q0+q1+q2+q3, no shifts (lane reduction)
// - FSM states: IDLE, ACCUM, DRAIN.
// - IDLE:
//   - start && len!=0 && mode!=11: latch len into cnt, latch mode, clear acc, go to ACCUM next cycle.
//   - start with len==0 or mode==11 is ignored: no output, stay IDLE.
// - ACCUM:
//   - in_ready=1 (combinational from state, independent of in_valid).
//   - Beat accepted when in_valid && in_ready: acc <= acc+term, cnt <= cnt-1.
//   - Accepted beat with cnt==1: out_data <= acc+term, out_valid <= 1, go to DRAIN.
//   - No beat: hold acc and cnt.
// - DRAIN:
//   - in_ready=0; out_data/out_valid held stable until out_ready.
//   - out_valid && out_ready: out_valid <= 0, go to IDLE.
//   - A start in the same cycle as the handshake is ignored; start is only honoured in IDLE.
// - Latency: out_valid asserts the cycle after the last beat is accepted.
//   - Minimum IDLE-to-IDLE time for len=1 with out_ready tied high is 3 cycles.
// - start outside IDLE is ignored; len and mode are not re-sampled.
// - flush (any state): next cycle state=IDLE, acc=0, cnt=0, out_valid=0.
//   - flush has priority over start, the beat handshake and the out handshake.
//   - A beat presented with flush is dropped.
// - rst mid-operation behaves identically to flush, plus out_data=0.
// - Overflow default: two's-complement wrap modulo 2**ACC_W.
// CONFIGURATION
// - FUSION_ACC_SAT_EN defined:
//   - each acc+term is clamped to [-(2**(ACC_W-1)), 2**(ACC_W-1)-1];
//   - sticky sat flag bit is cleared on start and appended as out_sat (out, 1), valid with out_valid.
// - FUSION_ACC_SAT_EN undefined: wrap arithmetic; no out_sat port.
// TESTING
// - 8b product: mode=00, len=1, q0=3,q1=2,q2=3,q3=2 -> out_data=595 (0x23*0x11), out_valid 1 cycle after beat.
// - 4b dot product: mode=01, len=3, q0..q3=-1 each beat -> out_data=-12; in_ready low in IDLE and DRAIN.
// - Backpressure and bubbles:
//   - len=4, in_valid toggled 1010..., out_ready low 5 cycles -> sum of 4 accepted beats only;
//   - out_data stable while out_valid && !out_ready; busy high until handshake.
// - Flush mid-op: len=8, flush after beat 3 -> IDLE next cycle, no out_valid.
//   - A new start len=1, q0=5 (others 0) then -> out_data=5.
// - Ignored starts: start len=0 -> no activity; start during ACCUM with len=9 -> original len honoured.
// - Overflow, ACC_W=26, mode=00, q3=0x7FFF (others 0), len=5:
//   - FUSION_ACC_SAT_EN defined -> out_data=33554431, out_sat=1;
//   - undefined -> out_data=-25167104.

Source files
------------

// File: rtl/fusion_accumulator_if.sv
// rtl/fusion_accumulator_if.sv - control, beat and result handshake bundle for fusion_accumulator
// FUSION_ACC_SAT_EN adds the out_sat result flag.
interface fusion_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        len;
    logic [1:0]              mode;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [15:0]      q0;
    logic signed [15:0]      q1;
    logic signed [15:0]      q2;
    logic signed [15:0]      q3;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;
`ifdef FUSION_ACC_SAT_EN
    logic                    out_sat;
`endif

    modport master (
        output start, len, mode, flush, in_valid, q0, q1, q2, q3, out_ready,
`ifdef FUSION_ACC_SAT_EN
        input  out_sat,
`endif
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, len, mode, flush, in_valid, q0, q1, q2, q3, out_ready,
`ifdef FUSION_ACC_SAT_EN
        output out_sat,
`endif
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fusion_accumulator.sv
// rtl/fusion_accumulator.sv - shift-combines quarter products and accumulates a dot product
// FUSION_ACC_SAT_EN: clamp each partial sum to ACC_W signed range and report a sticky out_sat.
module fusion_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    fusion_accumulator_if.slave bus
);
    if (ACC_W < 26 || ACC_W > 48) begin : g_bad_acc_w
        $error("fusion_accumulator: ACC_W must be within 26..48");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              mode_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;

    logic signed [ACC_W-1:0] q0_x, q1_x, q2_x, q3_x;
    logic signed [ACC_W-1:0] term_d;
    logic signed [ACC_W-1:0] acc_d;
`ifdef FUSION_ACC_SAT_EN
    logic signed [ACC_W:0]   sum_w;
    logic                    sat_hit_d;
    logic                    sat_q;
`endif

    always_comb begin
        q0_x = {{(ACC_W-16){bus.q0[15]}}, bus.q0};
        q1_x = {{(ACC_W-16){bus.q1[15]}}, bus.q1};
        q2_x = {{(ACC_W-16){bus.q2[15]}}, bus.q2};
        q3_x = {{(ACC_W-16){bus.q3[15]}}, bus.q3};
        // 8b mode weights the cross products by 16 and hi*hi by 256; narrower modes just reduce lanes
        if (mode_q == 2'b00) begin
            term_d = q0_x + (q1_x <<< 4) + (q2_x <<< 4) + (q3_x <<< 8);
        end else begin
            term_d = q0_x + q1_x + q2_x + q3_x;
        end
`ifdef FUSION_ACC_SAT_EN
        sum_w     = {acc_q[ACC_W-1], acc_q} + {term_d[ACC_W-1], term_d};
        sat_hit_d = 1'b0;
        acc_d     = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            sat_hit_d = 1'b1;
            acc_d     = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        acc_d = acc_q + term_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef FUSION_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else if (bus.flush) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && bus.len != '0 && bus.mode != 2'b11) begin
                        cnt_q   <= bus.len;
                        mode_q  <= bus.mode;
                        acc_q   <= '0;
                        state_q <= ACCUM;
`ifdef FUSION_ACC_SAT_EN
                        sat_q   <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
`ifdef FUSION_ACC_SAT_EN
                        sat_q <= sat_q | sat_hit_d;
`endif
                        if (cnt_q == CNT_W'(1)) begin
                            out_data_q  <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`ifdef FUSION_ACC_SAT_EN
    assign bus.out_sat   = sat_q;
`endif
endmodule
